// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
//   Constants and types shared by the RV32I pipeline stages (fetch, decode,
//   hazard logic).
//
//   NOP_INSTR        : canonical RV32I no-op (addi x0, x0, 0), used for bubbles
//   RESET_PC_DEFAULT : default program counter after reset
//   INSTR_BYTES      : byte distance between consecutive instructions
//   fetch_state_t    : fetch-stage IF/ID source selector
//                        BOOT - first cycle after reset, no fetched data yet
//                        RUN  - decode instruction comes from instruction memory
//                        HOLD - decode instruction comes from the hold buffer
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

endpackage : pipeline_pkg

// File: rtl/pc_register.sv
// -----------------------------------------------------------------------------
// pc_register
//   Program-counter flop of the fetch stage. Update priority on each rising
//   edge: reset > redirect (load target) > stall (hold) > increment by one
//   instruction. The increment wraps modulo 2^DATA_WIDTH and the redirect
//   target is loaded unmodified (no alignment check).
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous reset, active-high (loads RESET_PC)
//     redirect_i in   taken branch / jump redirect from execute
//     stall_i    in   hold the current PC
//     target_i   in   redirect target address
//     pc_o       out  current fetch PC
// -----------------------------------------------------------------------------
module pc_register
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_i,
  input  logic                  stall_i,
  input  logic [DATA_WIDTH-1:0] target_i,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;

  // Redirect outranks stall: a taken branch must never be lost because the
  // hazard unit happens to be holding fetch in the same cycle.
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    pc_d = pc_q + DATA_WIDTH'(INSTR_BYTES);
    if (redirect_i) begin
      pc_d = target_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_register

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined RV32I core; producer side of the
//   IF/ID boundary. Owns the PC (via pc_register), drives the synchronous
//   instruction memory and presents InstrD / PCD / PCPlus4D / ValidD to decode.
//
//   Because the instruction memory has one cycle of read latency, the
//   instruction shown to decode normally comes straight from imem_rdata. When
//   decode stalls, the memory output cannot be relied on to stay put, so the
//   current instruction is captured into instr_hold_q and shown from there
//   until the stall releases. Redirects and flushes turn the slot into a NOP
//   bubble and mask the (stale) memory data until the next advance.
//
//   Ports:
//     clk         in   clock, rising edge
//     rst         in   synchronous reset, active-high
//     StallF      in   hold PC (hazard unit)
//     StallD      in   hold IF/ID contents (hazard unit)
//     FlushD      in   squash IF/ID contents (hazard unit)
//     PCSrcE      in   taken branch / jump redirect from execute
//     PCTargetE   in   redirect target
//     imem_addr   out  instruction memory address (= PCF)
//     imem_rdata  in   instruction memory data, registered, one cycle latency
//     PCF         out  current fetch PC
//     InstrD      out  instruction presented to decode
//     PCD         out  PC of InstrD
//     PCPlus4D    out  PCD + 4 (wrapping)
//     ValidD      out  InstrD is a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallF,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  logic [DATA_WIDTH-1:0] pcf;
  logic [DATA_WIDTH-1:0] pcd_q;
  logic [DATA_WIDTH-1:0] instr_hold_q;
  logic [DATA_WIDTH-1:0] instr_cur;
  logic                  valid_q;
  logic                  squash_q;
  logic                  squash;
  fetch_state_t          state_q;

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  pc_register #(
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .rst        (rst),
    .redirect_i (PCSrcE),
    .stall_i    (StallF),
    .target_i   (PCTargetE),
    .pc_o       (pcf)
  );

  // A redirect squashes decode on its own; the hazard unit does not have to
  // raise FlushD as well.
  assign squash = PCSrcE | FlushD;

  // ---------------------------------------------------------------------------
  // Decode-side instruction source
  //   The squash flag masks imem_rdata, which at that point still carries the
  //   word fetched from the wrong path.
  // ---------------------------------------------------------------------------
  always_comb begin
    instr_cur = imem_rdata;
    if (state_q == BOOT || squash_q) begin
      instr_cur = NOP;
    end else if (state_q == HOLD) begin
      instr_cur = instr_hold_q;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register, hold buffer and source-select FSM
  //   Priority: reset > squash > stall > advance.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BOOT;
      pcd_q        <= '0;
      valid_q      <= 1'b0;
      squash_q     <= 1'b0;
      instr_hold_q <= NOP;
    end else if (squash) begin
      // PCD is left as-is; it is meaningless while ValidD is low.
      valid_q  <= 1'b0;
      squash_q <= 1'b1;
      state_q  <= RUN;
    end else if (StallD) begin
      case (state_q)
        // Nothing has been fetched yet: keep presenting the boot bubble
        // through the squash mask rather than exposing undefined memory data.
        BOOT: begin
          squash_q <= 1'b1;
          state_q  <= RUN;
        end
        // Capture what decode sees now; imem_rdata may change under the stall.
        RUN: begin
          instr_hold_q <= instr_cur;
          state_q      <= HOLD;
        end
        HOLD: begin
          state_q <= HOLD;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end else begin
      // On a HOLD exit, PCF was held during the stall, so imem_rdata already
      // carries mem[PCF] -- exactly the next instruction.
      pcd_q    <= pcf;
      valid_q  <= 1'b1;
      squash_q <= 1'b0;
      state_q  <= RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr = pcf;
  assign PCF       = pcf;
  assign InstrD    = instr_cur;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pcd_q + DATA_WIDTH'(INSTR_BYTES);
  assign ValidD    = valid_q;

endmodule : fetch_stage
